// File: rtl/led_routine_pkg.sv
// led_routine_pkg: shared mode encoding, segment indices and ring-to-segment mapping
package led_routine_pkg;

    typedef enum logic [1:0] {
        MODE_ROTATE = 2'd0,
        MODE_BOUNCE = 2'd1,
        MODE_FILL   = 2'd2
    } mode_e;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Outer-ring position -> flat segment bit: tops right-to-left... walked clockwise from the leftmost A
    function automatic int ring_seg(input int idx, input int digits);
        return (idx < digits)         ? 7 * (digits - 1 - idx) + SEG_A :
               (idx == digits)        ? SEG_B :
               (idx == digits + 1)    ? SEG_C :
               (idx < 2 * digits + 2) ? 7 * (idx - digits - 2) + SEG_D :
               (idx == 2 * digits + 2)? 7 * (digits - 1) + SEG_E :
                                        7 * (digits - 1) + SEG_F;
    endfunction

endpackage

// File: rtl/routine_tick_gen.sv
// routine_tick_gen: divides the clock into one-cycle animation ticks, frozen while disabled
module routine_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == CW'(TICK_DIV - 1));

    // Divider counts enabled clocks and wraps on the tick
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (o_tick)
            r_cnt <= '0;
        else if (i_enable)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/led_ssd_chaser.sv
// led_ssd_chaser: LED chaser (rotate/bounce/fill) plus a segment snake around a 7SD ring
module led_ssd_chaser
    import led_routine_pkg::*;
#(
    parameter int LED_COUNT   = 18,
    parameter int CHASE_WIDTH = 4,
    parameter int DIGITS      = 4,
    parameter int SNAKE_LEN   = 3,
    parameter int TICK_DIV    = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    input  logic [1:0]            i_mode,
    output logic [LED_COUNT-1:0]  o_led,
    output logic [7*DIGITS-1:0]   o_ssd,
    output logic                  o_frame_sync
);
    localparam int P  = 2 * DIGITS + 4;
    localparam int HW = $clog2(P);
    localparam logic [LED_COUNT-1:0] L_START = {{(LED_COUNT-CHASE_WIDTH){1'b0}}, {CHASE_WIDTH{1'b1}}};

    logic                 w_tick;
    logic [1:0]           r_mode;
    logic                 r_dir;
    logic                 r_phase;
    logic [LED_COUNT-1:0] r_led;
    logic [HW-1:0]        r_head;
    logic [7*DIGITS-1:0]  r_ssd;
    logic                 r_fs;
    logic                 w_left;
    logic                 w_fill_bit;
    logic [LED_COUNT-1:0] w_next_led;
    logic [LED_COUNT-1:0] w_start;
    logic [HW-1:0]        w_head_next;

    // Lit-segment map for a snake whose head sits at ring position h
    function automatic logic [7*DIGITS-1:0] snake_map(input logic [HW-1:0] h);
        snake_map = '0;
        for (int k = 0; k < SNAKE_LEN; k++)
            snake_map[ring_seg((int'(h) + P - k) % P, DIGITS)] = 1'b1;
    endfunction

    routine_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_enable (i_enable),
        .o_tick   (w_tick)
    );

    // Next LED pattern and direction/phase decisions; r_dir 1 = moving right, r_phase 1 = draining
    always_comb begin
        w_left      = r_dir ? r_led[0] : !r_led[LED_COUNT-1];
        w_fill_bit  = r_phase ? (r_led == '0) : !(&r_led);
        w_next_led  = (r_mode == MODE_BOUNCE) ? (w_left ? r_led << 1 : r_led >> 1) :
                      (r_mode == MODE_FILL)   ? {r_led[LED_COUNT-2:0], w_fill_bit} :
                                                {r_led[LED_COUNT-2:0], r_led[LED_COUNT-1]};
        w_start     = (i_mode == MODE_FILL) ? '0 : L_START;
        w_head_next = (r_head == HW'(P - 1)) ? '0 : r_head + 1'b1;
    end

    // LED engine: reload start pattern on a mode change, otherwise step the active mode
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode  <= MODE_ROTATE;
            r_dir   <= 1'b0;
            r_phase <= 1'b0;
            r_led   <= L_START;
        end else if (w_tick) begin
            if (i_mode != r_mode) begin
                r_mode  <= i_mode;
                r_dir   <= 1'b0;
                r_phase <= 1'b0;
                r_led   <= w_start;
            end else begin
                r_led   <= w_next_led;
                r_dir   <= (r_mode == MODE_BOUNCE) ? !w_left : r_dir;
                r_phase <= (r_mode == MODE_FILL) ? !w_fill_bit : r_phase;
            end
        end
    end

    // Snake engine: advance head each tick, pulse frame sync on the wrap to position 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head <= HW'(SNAKE_LEN - 1);
            r_ssd  <= ~snake_map(HW'(SNAKE_LEN - 1));
            r_fs   <= 1'b0;
        end else begin
            r_fs <= w_tick && (r_head == HW'(P - 1));
            if (w_tick) begin
                r_head <= w_head_next;
                r_ssd  <= ~snake_map(w_head_next);
            end
        end
    end

    assign o_led        = r_led;
    assign o_ssd        = r_ssd;
    assign o_frame_sync = r_fs;

endmodule

// File: tb/tb_led_ssd_chaser.sv
// tb_led_ssd_chaser: directed + random stimulus on two divider settings against a tick-count model
module tb_led_ssd_chaser;
    localparam int N  = 18;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int SL = 3;
    localparam int P  = 2 * D + 4;

    typedef struct {
        int         div;
        logic [1:0] mode;
        int         t;
        int         h;
        bit         fs;
    } mdl_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b1;
    logic [1:0]   mode = 2'd0;
    logic [N-1:0] led [2];
    logic [7*D-1:0] ssd [2];
    logic         fs [2];

    int   checks = 0;
    int   errors = 0;
    int   ring [P];
    mdl_t m [2];
    int   td [2] = '{1, 3};

    led_ssd_chaser #(.TICK_DIV(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode),
        .o_led(led[0]), .o_ssd(ssd[0]), .o_frame_sync(fs[0])
    );

    led_ssd_chaser #(.TICK_DIV(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_mode(mode),
        .o_led(led[1]), .o_ssd(ssd[1]), .o_frame_sync(fs[1])
    );

    always #5 clk = ~clk;

    // LED pattern as a closed-form function of ticks spent in the current mode
    function automatic logic [N-1:0] led_model(input logic [1:0] md, input int t);
        automatic logic [N-1:0] v = '0;
        automatic int L = N - W;
        automatic int u, p, c;
        if (md == 2'd1) begin
            u = t % (2 * L);
            p = (u <= L) ? u : 2 * L - u;
            for (int i = 0; i < W; i++) v[p + i] = 1'b1;
        end else if (md == 2'd2) begin
            c = t % (2 * N);
            if (c <= N) for (int i = 0; i < c; i++) v[i] = 1'b1;
            else for (int i = c - N; i < N; i++) v[i] = 1'b1;
        end else begin
            for (int i = 0; i < W; i++) v[(t + i) % N] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7*D-1:0] ssd_model(input int h);
        automatic logic [7*D-1:0] v = '0;
        for (int k = 0; k < SL; k++) v[ring[(h - k + P) % P]] = 1'b1;
        return ~v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < 2; j++) m[j] = '{div: 0, mode: 2'd0, t: 0, h: SL - 1, fs: 1'b0};
    endtask

    task automatic model_clock();
        for (int j = 0; j < 2; j++) begin
            automatic bit tk = en && (m[j].div == td[j] - 1);
            m[j].fs = tk && (m[j].h == P - 1);
            if (en) m[j].div = tk ? 0 : m[j].div + 1;
            if (tk) begin
                if (mode != m[j].mode) begin
                    m[j].mode = mode;
                    m[j].t = 0;
                end else begin
                    m[j].t++;
                end
                m[j].h = (m[j].h + 1) % P;
            end
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("led_div%0d", td[j]), 32'(led[j]), 32'(led_model(m[j].mode, m[j].t)));
            chk($sformatf("ssd_div%0d", td[j]), 32'(ssd[j]), 32'(ssd_model(m[j].h)));
            chk($sformatf("fsync_div%0d", td[j]), 32'(fs[j]), 32'(m[j].fs));
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            model_clock();
            #1 check_all();
        end
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < D; i++) ring[i] = 7 * (D - 1 - i);
        ring[D] = 1;
        ring[D + 1] = 2;
        for (int i = 0; i < D; i++) ring[D + 2 + i] = 7 * i + 3;
        ring[2 * D + 2] = 7 * (D - 1) + 4;
        ring[2 * D + 3] = 7 * (D - 1) + 5;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_all();
        chk("reset_led_const", 32'(led[0]), 32'h0000F);
        chk("reset_ssd_const", 32'(ssd[0]), 32'h0FDFBF7F);
        #7 rst_n = 1'b1;
        mode = 2'd0; step(40);
        mode = 2'd1; step(40);
        mode = 2'd2; step(120);
        mode = 2'd3; step(10);
        mode = 2'd0; step(5);
        step(1); en = 1'b0; step(5); en = 1'b1; step(10);
        step(2); en = 1'b0; step(5); en = 1'b1; step(10);
        mode = 2'd1; step(7);
        reset_pulse();
        step(20);
        mode = 2'd2; step(9);
        reset_pulse();
        step(15);
        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 499) == 0) reset_pulse();
            step(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
